// File: rtl/bcd_digit_serializer.sv
// Serializes a signed packed-BCD word into one-hot decimal digit beats.
// Beats go out most significant digit first over a valid/ready handshake.
// Leading zero digits can optionally be skipped.
module bcd_digit_serializer #(
   parameter int NDIGITS     = 3,
   parameter bit SUPPRESS_LZ = 1'b1,
   localparam int W          = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [4*NDIGITS-1:0]   in_bcd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [9:0]             out_dec,
   output logic                   out_neg,
   output logic [W-1:0]           out_pos,
   output logic                   out_last,
   output logic                   out_err
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [4*NDIGITS-1:0]   r_bcd;
   logic [W-1:0]           r_idx;
   logic                   r_neg;
   logic [9:0]             r_dec;
   logic                   r_last;
   logic                   r_err;
   logic                   w_accept;
   logic                   w_advance;
   logic                   w_finish;
   logic [W-1:0]           w_startIdx;
   logic [W-1:0]           w_nextIdx;
   logic [3:0]             w_startNibble;
   logic [3:0]             w_nextNibble;

   // Picks nibble idx out of a packed BCD word; out-of-range indices read as zero.
   function automatic logic [3:0] nibbleAt(input logic [4*NDIGITS-1:0] bcd,
                                           input logic [W-1:0] idx);
      logic [3:0] result;
      result = 4'd0;
      for (int k = 0; k < NDIGITS; k++) begin
         if (idx == W'(k)) begin
            result = bcd[4*k +: 4];
         end
      end
      return result;
   endfunction

   // One-hot decode of a digit; nibbles above 9 give an all-zero line.
   function automatic logic [9:0] decodeDigit(input logic [3:0] nib);
      return (nib <= 4'd9) ? (10'd1 << nib) : 10'd0;
   endfunction

   // Handshake status comes straight from the FSM state.
   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == EMIT);
   assign out_dec   = r_dec;
   assign out_neg   = r_neg;
   assign out_pos   = r_idx;
   assign out_last  = r_last;
   assign out_err   = r_err;

   assign w_nextIdx     = r_idx - W'(1);
   assign w_startNibble = nibbleAt(in_bcd, w_startIdx);
   assign w_nextNibble  = nibbleAt(r_bcd, w_nextIdx);

   // First digit to send: the highest non-zero nibble when skipping leading
   // zeros (invalid nibbles count as non-zero), otherwise always the top digit.
   always_comb begin
      w_startIdx = '0;
      if (SUPPRESS_LZ) begin
         for (int k = 0; k < NDIGITS; k++) begin
            if (in_bcd[4*k +: 4] != 4'd0) begin
               w_startIdx = W'(k);
            end
         end
      end else begin
         w_startIdx = W'(NDIGITS - 1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic plus the accept/advance/finish strobes that steer the datapath.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_nextState = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (r_idx == '0) begin
                  w_finish    = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Beat registers: load the first beat on accept, the next lower digit on each
   // completed beat, and clear once the word is done. A stalled beat simply holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bcd  <= '0;
         r_idx  <= '0;
         r_neg  <= 1'b0;
         r_dec  <= '0;
         r_last <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_bcd  <= in_bcd;
         r_idx  <= w_startIdx;
         r_neg  <= in_sign & (in_bcd != '0);
         r_dec  <= decodeDigit(w_startNibble);
         r_err  <= (w_startNibble > 4'd9);
         r_last <= (w_startIdx == '0);
      end else if (w_advance) begin
         r_idx  <= w_nextIdx;
         r_dec  <= decodeDigit(w_nextNibble);
         r_err  <= (w_nextNibble > 4'd9);
         r_last <= (w_nextIdx == '0);
      end else if (w_finish) begin
         r_idx  <= '0;
         r_neg  <= 1'b0;
         r_dec  <= '0;
         r_last <= 1'b0;
         r_err  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_digit_serializer.sv
// Bench for bcd_digit_serializer: a leading-zero-suppressing instance and a
// full-width instance share clock, reset, word inputs and out_ready.
module tb_bcd_digit_serializer;

   localparam int NDIG = 3;
   localparam int PW   = 2;

   typedef struct packed {
      logic [9:0]    dec;
      logic          neg;
      logic [PW-1:0] pos;
      logic          last;
      logic          err;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            inValid = 1'b0;
   logic            inValid2 = 1'b0;
   logic            inSign = 1'b0;
   logic [11:0]     inBcd = 12'h000;
   logic            outReady = 1'b1;

   logic            inReady, outValid, outNeg, outLast, outErr;
   logic [9:0]      outDec;
   logic [PW-1:0]   outPos;
   logic            inReady2, outValid2, outNeg2, outLast2, outErr2;
   logic [9:0]      outDec2;
   logic [PW-1:0]   outPos2;

   beat_t           expQ[$];
   int              checks = 0;
   int              errors = 0;

   bcd_digit_serializer #(.NDIGITS(NDIG), .SUPPRESS_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
      .in_sign(inSign), .in_bcd(inBcd), .out_valid(outValid), .out_ready(outReady),
      .out_dec(outDec), .out_neg(outNeg), .out_pos(outPos), .out_last(outLast),
      .out_err(outErr));

   bcd_digit_serializer #(.NDIGITS(NDIG), .SUPPRESS_LZ(1'b0)) dutFull (
      .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2),
      .in_sign(inSign), .in_bcd(inBcd), .out_valid(outValid2), .out_ready(outReady),
      .out_dec(outDec2), .out_neg(outNeg2), .out_pos(outPos2), .out_last(outLast2),
      .out_err(outErr2));

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case something wedges the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic beat_t observe(input bit sel);
      beat_t b;
      if (sel) b = '{dec: outDec2, neg: outNeg2, pos: outPos2, last: outLast2, err: outErr2};
      else     b = '{dec: outDec,  neg: outNeg,  pos: outPos,  last: outLast,  err: outErr};
      return b;
   endfunction

   function automatic logic obsValid(input bit sel);
      return sel ? outValid2 : outValid;
   endfunction

   function automatic logic obsReady(input bit sel);
      return sel ? inReady2 : inReady;
   endfunction

   // Reference model: expected beats for one word.
   task automatic pushModel(input bit sign, input logic [11:0] bcd, input bit suppress);
      int         start;
      logic [3:0] nib;
      beat_t      b;
      start = NDIG - 1;
      if (suppress) begin
         start = 0;
         for (int k = 0; k < NDIG; k++) if (bcd[4*k +: 4] != 4'd0) start = k;
      end
      for (int k = start; k >= 0; k--) begin
         nib    = bcd[4*k +: 4];
         b.dec  = (nib <= 4'd9) ? (10'd1 << nib) : 10'd0;
         b.err  = (nib > 4'd9);
         b.neg  = sign && (bcd != 12'h000);
         b.pos  = PW'(k);
         b.last = (k == 0);
         expQ.push_back(b);
      end
   endtask

   // Present a word to one instance until it is accepted (inputs change on negedge).
   task automatic applyStimulus(input bit sel, input bit sign, input logic [11:0] bcd);
      int waitCycles = 0;
      while (obsReady(sel) !== 1'b1 && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checks++;
      if (obsReady(sel) !== 1'b1) begin
         errors++;
         $display("[TB] FAIL in_ready_before_send: got %b want 1", obsReady(sel));
      end
      inSign = sign;
      inBcd  = bcd;
      if (sel) inValid2 = 1'b1;
      else     inValid  = 1'b1;
      pushModel(sign, bcd, !sel);
      @(posedge clk);
      @(negedge clk);
      inValid  = 1'b0;
      inValid2 = 1'b0;
   endtask

   // Pop and compare every expected beat; optionally stall one beat.
   task automatic checkOutput(input bit sel, input int stallBeat, input int stallCycles,
                              input string name);
      int    beat = 0;
      int    budget = 0;
      beat_t expBeat;
      beat_t obs;
      outReady = 1'b1;
      while (expQ.size() > 0 && budget < 40) begin
         budget++;
         checks++;
         if (obsValid(sel) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_valid beat %0d: got %b want 1", name, beat, obsValid(sel));
            @(negedge clk);
            continue;
         end
         expBeat = expQ.pop_front();
         obs     = observe(sel);
         checks++;
         if (obs !== expBeat) begin
            errors++;
            $display("[TB] FAIL %s_beat %0d: got dec=%b neg=%b pos=%0d last=%b err=%b want dec=%b neg=%b pos=%0d last=%b err=%b",
                     name, beat, obs.dec, obs.neg, obs.pos, obs.last, obs.err,
                     expBeat.dec, expBeat.neg, expBeat.pos, expBeat.last, expBeat.err);
         end
         if (beat == stallBeat) begin
            outReady = 1'b0;
            for (int s = 0; s < stallCycles; s++) begin
               @(negedge clk);
               obs = observe(sel);
               checks++;
               if (obsValid(sel) !== 1'b1 || obs !== expBeat) begin
                  errors++;
                  $display("[TB] FAIL %s_stall %0d: got valid=%b beat=%h want valid=1 beat=%h",
                           name, s, obsValid(sel), obs, expBeat);
               end
            end
            outReady = 1'b1;
         end
         @(negedge clk);
         beat++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s_timeout: got %0d beats left want 0", name, expQ.size());
         expQ.delete();
      end
      checks++;
      if (obsValid(sel) !== 1'b0 || obsReady(sel) !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_end: got valid=%b ready=%b want valid=0 ready=1",
                  name, obsValid(sel), obsReady(sel));
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      inValid = 1'b1;
      inValid2 = 1'b1;
      inBcd   = 12'h123;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (outValid !== 1'b0 || outDec !== 10'd0 || inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_state: got valid=%b dec=%b ready=%b want 0/0/1",
                  outValid, outDec, inReady);
      end
      checks++;
      if (outValid2 !== 1'b0 || outDec2 !== 10'd0 || inReady2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_state_full: got valid=%b dec=%b ready=%b want 0/0/1",
                  outValid2, outDec2, inReady2);
      end
      rst      = 1'b0;
      inValid  = 1'b0;
      inValid2 = 1'b0;
      @(negedge clk);
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_no_accept: got valid=%b ready=%b want 0/1", outValid, inReady);
      end
   endtask

   task automatic test_word_347();
      applyStimulus(1'b0, 1'b0, 12'h347);
      checkOutput(1'b0, -1, 0, "w347");
   endtask

   task automatic test_neg_five();
      applyStimulus(1'b0, 1'b1, 12'h005);
      checkOutput(1'b0, -1, 0, "neg005");
      applyStimulus(1'b1, 1'b1, 12'h005);
      checkOutput(1'b1, -1, 0, "neg005_full");
   endtask

   task automatic test_neg_zero();
      applyStimulus(1'b0, 1'b1, 12'h000);
      checkOutput(1'b0, -1, 0, "neg000");
   endtask

   task automatic test_stall_err();
      applyStimulus(1'b0, 1'b0, 12'h3A2);
      checkOutput(1'b0, 1, 3, "stall3A2");
   endtask

   task automatic test_reset_midword();
      beat_t expBeat;
      beat_t obs;
      applyStimulus(1'b0, 1'b0, 12'h999);
      expBeat = expQ.pop_front();
      obs     = observe(1'b0);
      checks++;
      if (outValid !== 1'b1 || obs !== expBeat) begin
         errors++;
         $display("[TB] FAIL mid_first_beat: got valid=%b beat=%h want valid=1 beat=%h",
                  outValid, obs, expBeat);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1 || outDec !== 10'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got valid=%b ready=%b dec=%b want 0/1/0",
                  outValid, inReady, outDec);
      end
      rst = 1'b0;
      expQ.delete();
      @(negedge clk);
      checks++;
      if (outValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_dropped: got valid=%b want 0", outValid);
      end
      applyStimulus(1'b0, 1'b0, 12'h012);
      checkOutput(1'b0, -1, 0, "after_reset012");
   endtask

   task automatic test_back_to_back();
      logic [11:0] bcd;
      bit          sign;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < NDIG; k++) begin
            bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
         end
         if (i == 3) bcd[7:4] = 4'hC;
         sign = 1'($urandom_range(0, 1));
         applyStimulus(1'b0, sign, bcd);
         checkOutput(1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "b2b");
      end
   endtask

   initial begin
      test_reset();
      test_word_347();
      test_neg_five();
      test_neg_zero();
      test_stall_err();
      test_reset_midword();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
